// File: rtl/memwb_pkg.sv
// memwb_pkg: shared definitions for the MEM/WB stage slice.
// Holds the FSM state encoding, control-bus bit positions and default sizing.
package memwb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Bit positions inside wb_in / wb_out
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Bit positions inside m_in
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // Default configuration
  localparam int DEFAULT_MEM_LAT    = 2;
  localparam int DEFAULT_DEPTH_LOG2 = 8;

endpackage

// File: rtl/memwb_dmem.sv
// memwb_dmem: single-port data memory, synchronous write, combinational read
// of the addressed word. Contents are deliberately not reset.
module memwb_dmem #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Store the write data into the addressed word on a write strobe
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memwb_stage.sv
// memwb_stage: MEM stage with multi-cycle data memory and the MEM/WB register.
// Memory ops stall upstream for exactly MEM_LAT cycles, then the access
// executes and the result lands in the MEM/WB register.
// Optional macro MEMWB_ALIGN_CHECK_EN: unaligned memory ops are dropped and
// flagged with a one-cycle misalign pulse; without it misalign stays 0.
module memwb_stage
  import memwb_pkg::*;
#(
  parameter int MEM_LAT    = DEFAULT_MEM_LAT,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,
  input  logic [2:0]  m_in,
  input  logic [31:0] add2_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rd2_in,
  input  logic [4:0]  mux_in,
  input  logic        zero_in,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [1:0]  wb_out,
  output logic [31:0] rdata_out,
  output logic [31:0] alu_out,
  output logic [4:0]  rd_out,
  output logic        misalign
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  req_wb_q, req_wb_d;
  logic        req_rd_q, req_rd_d;
  logic        req_wr_q, req_wr_d;
  logic [31:0] req_alu_q, req_alu_d;
  logic [31:0] req_rd2_q, req_rd2_d;
  logic [4:0]  req_mux_q, req_mux_d;
  logic [1:0]  wb_q, wb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        misalign_q, misalign_d;

  logic                  mem_op;
  logic                  bad_align;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_rdata;

  assign mem_op = m_in[M_MEMREAD] | m_in[M_MEMWRITE];

`ifdef MEMWB_ALIGN_CHECK_EN
  assign bad_align = mem_op & (alu_in[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif

  // Word index ignores the byte offset and any bits above the memory size
  assign mem_addr = req_alu_q[DEPTH_LOG2+1:2];
  // A reset arriving on the execute cycle must not let the write through
  assign mem_we   = (state_q == BUSY) && (cnt_q == 4'd0) && req_wr_q && !rst;

  memwb_dmem #(.DEPTH_LOG2(DEPTH_LOG2)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (req_rd2_q),
    .rdata (mem_rdata)
  );

  assign branch_target = add2_in;
  assign pcsrc         = (state_q == IDLE) & m_in[M_BRANCH] & zero_in;

  // Next-state, stall and MEM/WB register update for the access FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_wb_d   = req_wb_q;
    req_rd_d   = req_rd_q;
    req_wr_d   = req_wr_q;
    req_alu_d  = req_alu_q;
    req_rd2_d  = req_rd2_q;
    req_mux_d  = req_mux_q;
    wb_d       = wb_q;
    rdata_d    = rdata_q;
    alu_d      = alu_q;
    rd_d       = rd_q;
    misalign_d = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bad_align) begin
          wb_d       = 2'b00;
          misalign_d = 1'b1;
        end else if (mem_op) begin
          stall     = 1'b1;
          req_wb_d  = wb_in;
          req_rd_d  = m_in[M_MEMREAD];
          req_wr_d  = m_in[M_MEMWRITE];
          req_alu_d = alu_in;
          req_rd2_d = rd2_in;
          req_mux_d = mux_in;
          cnt_d     = CNT_INIT;
          state_d   = BUSY;
          wb_d      = 2'b00;
        end else begin
          wb_d    = wb_in;
          alu_d   = alu_in;
          rd_d    = mux_in;
          rdata_d = 32'd0;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
          wb_d  = 2'b00;
        end else begin
          wb_d    = req_wb_q;
          alu_d   = req_alu_q;
          rd_d    = req_mux_q;
          rdata_d = (req_rd_q && !req_wr_q) ? mem_rdata : 32'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and MEM/WB register flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      req_wb_q   <= 2'b00;
      req_rd_q   <= 1'b0;
      req_wr_q   <= 1'b0;
      req_alu_q  <= 32'd0;
      req_rd2_q  <= 32'd0;
      req_mux_q  <= 5'd0;
      wb_q       <= 2'b00;
      rdata_q    <= 32'd0;
      alu_q      <= 32'd0;
      rd_q       <= 5'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_wb_q   <= req_wb_d;
      req_rd_q   <= req_rd_d;
      req_wr_q   <= req_wr_d;
      req_alu_q  <= req_alu_d;
      req_rd2_q  <= req_rd2_d;
      req_mux_q  <= req_mux_d;
      wb_q       <= wb_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
    end
  end

  assign wb_out    = wb_q;
  assign rdata_out = rdata_q;
  assign alu_out   = alu_q;
  assign rd_out    = rd_q;
  assign misalign  = misalign_q;

endmodule
